// File: rtl/afifo_pkg.sv
// Constants and FSM encoding shared by the afifo write-side arbiter and the afifo itself.
package afifo_pkg;

  localparam int DEF_NBITS = 8;
  localparam int DEF_DWDTH = DEF_NBITS + 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

endpackage

// File: rtl/afifo_wr_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr_i, wrapping to 0.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic [IW-1:0]   idx_o,
  output logic            found_o
);

  logic [IW:0] w_k;
  logic        w_hit;

  always_comb begin
    idx_o = '0;
    w_hit = 1'b0;
    w_k   = '0;
    for (int i = 0; i < NREQ; i++) begin
      // ptr and offset are both below NREQ, so a single subtraction wraps the sum
      w_k = {1'b0, ptr_i} + (IW+1)'(i);
      if (w_k >= (IW+1)'(NREQ)) w_k = w_k - (IW+1)'(NREQ);
      if (!w_hit && req_i[w_k[IW-1:0]]) begin
        w_hit = 1'b1;
        idx_o = w_k[IW-1:0];
      end
    end
    found_o = w_hit;
  end

endmodule

// File: rtl/afifo_wr_arb.sv
// Round-robin write arbiter in front of an async FIFO: bursts of up to BURST beats per grant.
module afifo_wr_arb
  import afifo_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int NBITS = DEF_NBITS,
  parameter int BURST = 4,
  parameter int IW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  wclk_i,
  input  logic                  wrstn_i,
  input  logic [NREQ-1:0]       req_vld_i,
  input  logic [NREQ*NBITS-1:0] req_data_i,
  output logic [NREQ-1:0]       req_rdy_o,
  output logic                  winc_o,
  output logic [NBITS:0]        wdata_o,
  input  logic                  fifo_full_i,
  input  logic                  fifo_ovflw_i,
  output logic [IW-1:0]         grant_id_o,
  output logic                  grant_vld_o,
  output logic                  ovflw_err_o,
  input  logic                  clr_err_i
);

  localparam int CW = $clog2(BURST + 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BURST - 1);
  localparam logic [IW-1:0] LAST_ID   = IW'(NREQ - 1);

  arb_state_t    r_state;
  logic [IW-1:0] r_grant_id;
  logic [IW-1:0] r_rr_ptr;
  logic [CW-1:0] r_beat_cnt;
  logic          r_ovflw_err;

  logic [IW-1:0]   w_win;
  logic            w_found;
  logic            w_own_vld;
  logic [NREQ-1:0] w_rdy;
  logic            w_winc;
  logic [IW-1:0]   w_ptr_nxt;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req_i   (req_vld_i),
    .ptr_i   (r_rr_ptr),
    .idx_o   (w_win),
    .found_o (w_found)
  );

  always_comb begin
    w_rdy = '0;
    if (r_state == ST_GRANT && !fifo_full_i) w_rdy[r_grant_id] = 1'b1;
  end

  // Handshake: a beat moves when the owner's vld and rdy are both high in the same cycle.
  assign w_own_vld = req_vld_i[r_grant_id];
  assign w_winc    = w_own_vld & w_rdy[r_grant_id];
  assign w_ptr_nxt = (r_grant_id == LAST_ID) ? '0 : r_grant_id + 1'b1;

  always_ff @(posedge wclk_i or negedge wrstn_i) begin
    if (!wrstn_i) begin
      r_state    <= ST_IDLE;
      r_grant_id <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state    <= ST_GRANT;
            r_grant_id <= w_win;
            r_beat_cnt <= '0;
          end
        end
        ST_GRANT: begin
          if (w_winc) r_beat_cnt <= r_beat_cnt + 1'b1;
          // A stalled owner (full) keeps the grant; only a dropped vld or the last beat releases it.
          if (!w_own_vld || (w_winc && r_beat_cnt == LAST_BEAT)) begin
            r_state  <= ST_IDLE;
            r_rr_ptr <= w_ptr_nxt;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Set wins over clear so an overflow coinciding with a clear is never lost.
  always_ff @(posedge wclk_i or negedge wrstn_i) begin
    if (!wrstn_i)          r_ovflw_err <= 1'b0;
    else if (fifo_ovflw_i) r_ovflw_err <= 1'b1;
    else if (clr_err_i)    r_ovflw_err <= 1'b0;
  end

  assign req_rdy_o   = w_rdy;
  assign winc_o      = w_winc;
  assign wdata_o     = w_winc ? {1'b1, req_data_i[r_grant_id*NBITS +: NBITS]} : '0;
  assign grant_id_o  = r_grant_id;
  assign grant_vld_o = (r_state == ST_GRANT);
  assign ovflw_err_o = r_ovflw_err;

endmodule

// File: tb/tb_afifo_wr_arb.sv
// Directed bench for afifo_wr_arb: per-cycle vector table plus multi-cycle burst sequences.
module tb_afifo_wr_arb;

  logic        wclk = 1'b0;
  logic        wrstn = 1'b0;
  logic [3:0]  req_vld = '0;
  logic [31:0] req_data = 32'hD3C2B1A0;
  logic [3:0]  req_rdy;
  logic        winc;
  logic [8:0]  wdata;
  logic        fifo_full = 1'b0;
  logic        fifo_ovflw = 1'b0;
  logic [1:0]  grant_id;
  logic        grant_vld;
  logic        ovflw_err;
  logic        clr_err = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 wclk = ~wclk;

  afifo_wr_arb #(.NREQ(4), .NBITS(8), .BURST(4)) dut (
    .wclk_i       (wclk),
    .wrstn_i      (wrstn),
    .req_vld_i    (req_vld),
    .req_data_i   (req_data),
    .req_rdy_o    (req_rdy),
    .winc_o       (winc),
    .wdata_o      (wdata),
    .fifo_full_i  (fifo_full),
    .fifo_ovflw_i (fifo_ovflw),
    .grant_id_o   (grant_id),
    .grant_vld_o  (grant_vld),
    .ovflw_err_o  (ovflw_err),
    .clr_err_i    (clr_err)
  );

  typedef struct {
    logic       rst;
    logic [3:0] vld;
    logic       full;
    logic       ovf;
    logic       clr;
    logic       gv;
    logic [1:0] gid;
    logic [3:0] rdy;
    logic       winc;
    logic [8:0] wdata;
    logic       err;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(logic rst, logic [3:0] vld, logic full, logic ovf, logic clr,
                              logic gv, logic [1:0] gid, logic [3:0] rdy, logic wi,
                              logic [8:0] wd, logic err);
    vec_t v;
    v.rst = rst; v.vld = vld; v.full = full; v.ovf = ovf; v.clr = clr;
    v.gv = gv; v.gid = gid; v.rdy = rdy; v.winc = wi; v.wdata = wd; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later, well before the rising edge.
  task automatic drive(input logic rst, input logic [3:0] vld, input logic full,
                       input logic ovf, input logic clr);
    @(negedge wclk);
    wrstn = rst; req_vld = vld; fifo_full = full; fifo_ovflw = ovf; clr_err = clr;
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 4'b0000, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int remain, cur, idle_cnt, stall_err;
    logic prev_gv;
    logic [3:0] exp_q[$];
    logic [3:0] bursts[$];
    logic [8:0] bq[$];
    int c_full[9] = '{0, 0, 1, 1, 1, 0, 0, 0, 0};
    int c_winc[9] = '{0, 1, 0, 0, 0, 1, 1, 1, 0};
    int c_gv[9]   = '{0, 1, 1, 1, 1, 1, 1, 1, 0};

    //              rst vld     full ovf clr  gv gid rdy     winc wdata   err
    tbl[0]  = mk(0, 4'b0000, 0, 0, 0,   0, 0, 4'b0000, 0, 9'h000, 0);
    tbl[1]  = mk(1, 4'b0000, 0, 0, 0,   0, 0, 4'b0000, 0, 9'h000, 0);
    tbl[2]  = mk(1, 4'b1010, 0, 0, 0,   0, 0, 4'b0000, 0, 9'h000, 0);
    tbl[3]  = mk(1, 4'b1010, 0, 0, 0,   1, 1, 4'b0010, 1, 9'h1B1, 0);
    tbl[4]  = mk(1, 4'b1010, 1, 0, 0,   1, 1, 4'b0000, 0, 9'h000, 0);
    tbl[5]  = mk(1, 4'b1010, 0, 0, 0,   1, 1, 4'b0010, 1, 9'h1B1, 0);
    tbl[6]  = mk(1, 4'b1000, 0, 0, 0,   1, 1, 4'b0010, 0, 9'h000, 0);
    tbl[7]  = mk(1, 4'b1001, 0, 0, 0,   0, 0, 4'b0000, 0, 9'h000, 0);
    tbl[8]  = mk(1, 4'b1001, 0, 1, 0,   1, 3, 4'b1000, 1, 9'h1D3, 0);
    tbl[9]  = mk(1, 4'b1001, 0, 1, 1,   1, 3, 4'b1000, 1, 9'h1D3, 1);
    tbl[10] = mk(1, 4'b1001, 0, 0, 1,   1, 3, 4'b1000, 1, 9'h1D3, 1);
    tbl[11] = mk(1, 4'b1001, 0, 0, 0,   1, 3, 4'b1000, 1, 9'h1D3, 0);
    tbl[12] = mk(1, 4'b1001, 0, 0, 0,   0, 0, 4'b0000, 0, 9'h000, 0);
    tbl[13] = mk(1, 4'b0001, 0, 0, 0,   1, 0, 4'b0001, 1, 9'h1A0, 0);
    tbl[14] = mk(0, 4'b0001, 0, 0, 0,   0, 0, 4'b0000, 0, 9'h000, 0);
    tbl[15] = mk(1, 4'b0100, 0, 0, 0,   0, 0, 4'b0000, 0, 9'h000, 0);
    tbl[16] = mk(1, 4'b0100, 0, 0, 0,   1, 2, 4'b0100, 1, 9'h1C2, 0);

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].rst, tbl[i].vld, tbl[i].full, tbl[i].ovf, tbl[i].clr);
      chk($sformatf("v%0d.gv", i), 32'(grant_vld), 32'(tbl[i].gv));
      chk($sformatf("v%0d.rdy", i), 32'(req_rdy), 32'(tbl[i].rdy));
      chk($sformatf("v%0d.winc", i), 32'(winc), 32'(tbl[i].winc));
      chk($sformatf("v%0d.wdata", i), 32'(wdata), 32'(tbl[i].wdata));
      chk($sformatf("v%0d.err", i), 32'(ovflw_err), 32'(tbl[i].err));
      if (tbl[i].gv || !tbl[i].rst)
        chk($sformatf("v%0d.gid", i), 32'(grant_id), 32'(tbl[i].gid));
    end

    // Req0 alone with 10 beats: bursts of 4, 4, 2 separated by one IDLE cycle.
    do_reset();
    remain = 10; cur = 0; idle_cnt = 0; stall_err = 0; prev_gv = 1'b0;
    exp_q = '{4'd4, 4'd4, 4'd2};
    for (int c = 0; c < 30; c++) begin
      drive(1'b1, {3'b000, remain > 0}, 1'b0, 1'b0, 1'b0);
      if (grant_vld && !prev_gv) begin
        if (bursts.size() > 0) chk("A.gap", 32'(idle_cnt), 32'd1);
        idle_cnt = 0;
      end
      if (!grant_vld) idle_cnt++;
      if (grant_vld && req_vld[0] && !winc) stall_err++;
      if (winc) begin
        chk("A.wdata", 32'(wdata), 32'h1A0);
        remain--;
        cur++;
      end
      if (!grant_vld && prev_gv) begin
        bursts.push_back(4'(cur));
        cur = 0;
      end
      prev_gv = grant_vld;
    end
    chk("A.nbursts", 32'(bursts.size()), 32'd3);
    chk("A.stalls", 32'(stall_err), 32'd0);
    while (exp_q.size() > 0 && bursts.size() > 0)
      chk("A.burst_len", 32'(bursts.pop_front()), 32'(exp_q.pop_front()));

    // All four requesters busy: order 0,1,2,3,0 with four beats each.
    do_reset();
    foreach (exp_q[i]) exp_q.delete(i);
    for (int g = 0; g < 5; g++)
      for (int b = 0; b < 4; b++)
        bq.push_back({1'b1, req_data[(g % 4)*8 +: 8]});
    for (int c = 0; c < 60 && bq.size() > 0; c++) begin
      drive(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
      if (winc) chk("B.beat", 32'(wdata), 32'(bq.pop_front()));
    end
    chk("B.left", 32'(bq.size()), 32'd0);

    // Req2 stalled by full for three cycles after its first beat.
    do_reset();
    for (int c = 0; c < 9; c++) begin
      drive(1'b1, 4'b0100, 1'(c_full[c]), 1'b0, 1'b0);
      chk($sformatf("C%0d.gv", c), 32'(grant_vld), 32'(c_gv[c]));
      chk($sformatf("C%0d.winc", c), 32'(winc), 32'(c_winc[c]));
      chk($sformatf("C%0d.rdy", c), 32'(req_rdy),
          (c_gv[c] == 1 && c_full[c] == 0) ? 32'h4 : 32'h0);
      if (c_gv[c] == 1) chk($sformatf("C%0d.gid", c), 32'(grant_id), 32'd2);
    end

    // Move rr_ptr off zero, reset mid-burst, then confirm arbitration restarts at req0.
    do_reset();
    drive(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0);
    chk("D.beat1", 32'(winc), 32'd1);
    drive(1'b1, 4'b0000, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'b0110, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'b0110, 1'b0, 1'b0, 1'b0);
    chk("D.owner2", 32'(grant_id), 32'd2);
    chk("D.owner2_winc", 32'(winc), 32'd1);
    drive(1'b0, 4'b0110, 1'b0, 1'b0, 1'b0);
    chk("D.rst_winc", 32'(winc), 32'd0);
    chk("D.rst_gv", 32'(grant_vld), 32'd0);
    chk("D.rst_rdy", 32'(req_rdy), 32'd0);
    chk("D.rst_wdata", 32'(wdata), 32'd0);
    drive(1'b0, 4'b0110, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
    chk("D.restart_gv", 32'(grant_vld), 32'd1);
    chk("D.restart_gid", 32'(grant_id), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
